// File: rtl/sdpb_burst_reader.sv
// sdpb_burst_reader: read-side sequencer for port B of the 512x32 simple
// dual-port line buffer.
//
// On start it latches base_addr/len and issues len sequential reads,
// wrapping modulo 2**ADDR_W. A 4-entry skid FIFO absorbs the RAM's 1-cycle
// read latency, and the words are presented as a valid/ready stream.
//
// Build option:
//   SDPB_RD_BSWAP_EN  when defined, m_data is the byte-reversed FIFO head
//                     (MSB-first SPI order). When undefined, m_data is the
//                     FIFO head unchanged. Timing is the same in both builds.
//
// Ports:
//   clk        single clock; also drives RAM clkb
//   reset_n    asynchronous active-low reset
//   start      burst request, sampled only in idle
//   base_addr  first word address, latched with start
//   len        word count, latched with start (0 = empty burst)
//   busy       high while a burst is reading or draining
//   done       1-cycle pulse after the final stream handshake
//   mem_adb    RAM read address
//   mem_ceb    RAM read enable, one read per high cycle
//   mem_oce    RAM output-register enable, tied high (bypass read mode)
//   mem_dout   RAM read data, valid the cycle after mem_ceb is sampled
//   m_data     stream data (FIFO head)
//   m_valid    stream valid
//   m_ready    stream ready

module sdpb_burst_reader #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_adb,
    output logic              mem_ceb,
    output logic              mem_oce,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rd_left_q, rd_left_d;    // reads still to issue
    logic [LEN_W-1:0]  out_left_q, out_left_d;  // words still to hand off

    // A read issued last cycle has its data on mem_dout this cycle.
    logic              rd_pend_q;

    logic [DATA_W-1:0] fifo_q [4];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        count_q, count_d;

    logic              issue;
    logic              push;
    logic              pop;
    logic [2:0]        used;
    logic [DATA_W-1:0] head;

    // Issue only if every in-flight word is guaranteed a FIFO slot.
    always_comb begin
        used  = count_q + {2'b00, rd_pend_q};
        issue = (state_q == StRead) && (used < 3'd4);
        push  = rd_pend_q;
        pop   = (count_q != 3'd0) && m_ready;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_left_d  = rd_left_q;
        out_left_d = out_left_q;

        if (pop) begin
            out_left_d = out_left_q - LEN_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d     = base_addr;
                    rd_left_d  = len;
                    out_left_d = len;
                    state_d    = (len == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (issue) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - LEN_W'(1);
                    if (rd_left_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && (out_left_q == LEN_W'(1))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rd_left_q  <= '0;
            out_left_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_left_q  <= rd_left_d;
            out_left_q <= out_left_d;
            rd_pend_q  <= issue;
        end
    end

    always_comb begin
        count_d = count_q + {2'b00, push} - {2'b00, pop};
    end

    // Storage is reset too so m_data reads zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_dout;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_d;
        end
    end

    assign head = fifo_q[rd_ptr_q];

    always_comb begin
        m_data = head;
`ifdef SDPB_RD_BSWAP_EN
        for (int i = 0; i < int'(DATA_W / 8); i++) begin
            m_data[8*i +: 8] = head[int'(DATA_W) - 8 - 8*i +: 8];
        end
`endif
    end

    assign m_valid = (count_q != 3'd0);
    assign busy    = (state_q == StRead) || (state_q == StDrain);
    assign done    = (state_q == StDone);
    assign mem_adb = addr_q;
    assign mem_ceb = issue;
    assign mem_oce = 1'b1;

endmodule
